// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if
// Purpose: groups the memory-stage snoop signals and the combinational
// load-return path between the pipelined core and the memory-mapped UART
// transmitter.
// Signals:
//   memwriteM   store strobe from the memory stage
//   dataAdrM    memory-stage byte address
//   writedataM  store data
//   selIO       high when dataAdrM hits the UART window
//   readDataIO  load data returned by the UART (STATUS or 0)
// Modports:
//   master  core side, drives the bus and receives selIO/readDataIO
//   slave   UART side
interface mmio_uart_tx_if;
   logic        memwriteM;
   logic [31:0] dataAdrM;
   logic [31:0] writedataM;
   logic        selIO;
   logic [31:0] readDataIO;

   modport master (
      output memwriteM, dataAdrM, writedataM,
      input  selIO, readDataIO
   );

   modport slave (
      input  memwriteM, dataAdrM, writedataM,
      output selIO, readDataIO
   );
endinterface

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
// Purpose: memory-mapped UART transmitter. Snoops memory-stage stores,
// claims TXDATA (BASE_ADDR) and STATUS (BASE_ADDR+4), queues stored bytes
// in a small FIFO and serialises them LSB first as 8N1 frames on tx.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit
// between the data bits and the stop bit (11-bit frames).
// Ports:
//   clock  single clock, rising edge
//   reset  synchronous active-high reset
//   bus    mmio_uart_tx_if.slave (memwriteM, dataAdrM, writedataM in;
//          selIO, readDataIO out, both combinational)
//   tx     registered serial output, idle high
//   busy   high while a frame is in progress
// STATUS: [0] full, [1] empty, [2] busy, [3] overflow (sticky; cleared by
// a store to STATUS with bit 3 set).
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 4
) (
   input  logic          clock,
   input  logic          reset,
   mmio_uart_tx_if.slave bus,
   output logic          tx,
   output logic          busy
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int PTR_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int IDX_W  = PTR_W - 1;
   localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t            r_state;
   state_t            w_nextState;
   logic [7:0]        r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wrPtr;
   logic [PTR_W-1:0]  r_rdPtr;
   logic              r_overflow;
   logic [7:0]        r_shift;
   logic [2:0]        r_bitCnt;
   logic [BAUD_W-1:0] r_baudCnt;
`ifdef UART_TX_PARITY_EN
   logic              r_parityBit;
`endif
   logic              w_fifoEmpty;
   logic              w_fifoFull;
   logic              w_hitData;
   logic              w_hitStatus;
   logic              w_push;
   logic              w_pop;
   logic              w_baudDone;
   logic [7:0]        w_head;
   logic              w_unusedBits;

   // Address decode and status are purely combinational so the top level
   // can mux readDataIO ahead of the data-memory read in the same cycle.
   assign w_hitData   = (bus.dataAdrM == BASE_ADDR);
   assign w_hitStatus = (bus.dataAdrM == STATUS_ADDR);
   assign bus.selIO   = w_hitData | w_hitStatus;
   assign busy        = (r_state != IDLE);
   assign bus.readDataIO = w_hitStatus ? {28'd0, r_overflow, busy, w_fifoEmpty, w_fifoFull} : 32'd0;

   // Pointers carry one extra wrap bit: equal pointers mean empty, equal
   // index with differing wrap bit means full.
   assign w_fifoEmpty = (r_wrPtr == r_rdPtr);
   assign w_fifoFull  = (r_wrPtr[PTR_W-1] != r_rdPtr[PTR_W-1]) &&
                        (r_wrPtr[IDX_W-1:0] == r_rdPtr[IDX_W-1:0]);
   assign w_push      = bus.memwriteM && w_hitData && !w_fifoFull;
   assign w_head      = r_mem[r_rdPtr[IDX_W-1:0]];
   assign w_baudDone  = (r_baudCnt == BAUD_LAST);
   assign w_unusedBits = ^{bus.writedataM[31:8]};

   // FIFO storage needs no reset; only the pointers define its contents.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wrPtr[IDX_W-1:0]] <= bus.writedataM[7:0];
      end
   end

   // Pointer and sticky overflow bookkeeping. Full is the pre-edge value,
   // so a pop on this edge never makes room for a push on this edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_wrPtr    <= '0;
         r_rdPtr    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         if (bus.memwriteM && w_hitData && w_fifoFull) begin
            r_overflow <= 1'b1;
         end else if (bus.memwriteM && w_hitStatus && bus.writedataM[3]) begin
            r_overflow <= 1'b0;
         end
      end
   end

   // State register for the frame sequencer.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. The last STOP cycle pops straight into START when
   // another byte is waiting, giving back-to-back frames with no idle bit.
   always_comb begin
      w_nextState = r_state;
      w_pop       = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_fifoEmpty) begin
               w_nextState = START;
               w_pop       = 1'b1;
            end
         end
         START: begin
            if (w_baudDone) begin
               w_nextState = DATA;
            end
         end
         DATA: begin
            if (w_baudDone && (r_bitCnt == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
               w_nextState = PARITY;
`else
               w_nextState = STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (w_baudDone) begin
               w_nextState = STOP;
            end
         end
`endif
         STOP: begin
            if (w_baudDone) begin
               if (!w_fifoEmpty) begin
                  w_nextState = START;
                  w_pop       = 1'b1;
               end else begin
                  w_nextState = IDLE;
               end
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Serial datapath. tx is updated at each bit boundary with the value of
   // the bit that is starting; the shift register is consumed LSB first.
   always_ff @(posedge clock) begin
      if (reset) begin
         tx        <= 1'b1;
         r_shift   <= 8'd0;
         r_bitCnt  <= 3'd0;
         r_baudCnt <= '0;
`ifdef UART_TX_PARITY_EN
         r_parityBit <= 1'b0;
`endif
      end else if (w_pop) begin
         tx        <= 1'b0;
         r_shift   <= w_head;
         r_bitCnt  <= 3'd0;
         r_baudCnt <= '0;
`ifdef UART_TX_PARITY_EN
         r_parityBit <= ^w_head;
`endif
      end else if (r_state != IDLE) begin
         if (w_baudDone) begin
            r_baudCnt <= '0;
            case (r_state)
               START: begin
                  tx      <= r_shift[0];
                  r_shift <= r_shift >> 1;
               end
               DATA: begin
                  if (r_bitCnt == 3'd7) begin
                     r_bitCnt <= 3'd0;
`ifdef UART_TX_PARITY_EN
                     tx <= r_parityBit;
`else
                     tx <= 1'b1;
`endif
                  end else begin
                     tx       <= r_shift[0];
                     r_shift  <= r_shift >> 1;
                     r_bitCnt <= r_bitCnt + 3'd1;
                  end
               end
               default: tx <= 1'b1;
            endcase
         end else begin
            r_baudCnt <= r_baudCnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx
// Purpose: self-checking bench for mmio_uart_tx with CLKS_PER_BIT=4 and
// FIFO_DEPTH=4. A frame monitor decodes tx into a queue of received frames
// (start time, data byte, start/stop/parity bits); directed tests compare
// decode, status and frames against hand-computed values.
// Honors UART_TX_PARITY_EN the same way as the design.
module tb_mmio_uart_tx;

   localparam logic [31:0] BASE = 32'h1000_0000;
   localparam int C = 4;
`ifdef UART_TX_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif

   typedef struct {
      int         startCycle;
      logic [7:0] data;
      logic       startOk;
      logic       parityBit;
      logic       stopOk;
   } frame_t;

   typedef struct {
      logic [31:0] adr;
      logic        expSel;
      logic [31:0] expRead;
   } decodeVec_t;

   typedef struct {
      logic [31:0] wdata;
      logic [7:0]  expByte;
      logic        expParity;
   } frameVec_t;

   logic clock;
   logic reset;
   logic tx;
   logic busy;
   int   cycle;
   int   checks;
   int   errors;
   frame_t frames[$];

   mmio_uart_tx_if bus();

   mmio_uart_tx #(
      .BASE_ADDR(BASE),
      .CLKS_PER_BIT(C),
      .FIFO_DEPTH(4)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus),
      .tx(tx),
      .busy(busy)
   );

   // Free-running clock and cycle counter used to time frame starts.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial cycle = 0;
   always @(posedge clock) cycle <= cycle + 1;

   // Frame monitor: detects a start bit on a falling-edge sample, then samples
   // each bit in its middle. It re-arms exactly one frame length after the
   // start, so a contiguous next frame is caught on its first cycle.
   always begin : monitor
      frame_t rec;
      @(negedge clock);
      if (tx === 1'b0) begin
         rec.startCycle = cycle;
         rec.parityBit  = 1'b0;
         repeat (C/2) @(negedge clock);
         rec.startOk = (tx === 1'b0);
         for (int b = 0; b < 8; b++) begin
            repeat (C) @(negedge clock);
            rec.data[b] = tx;
         end
`ifdef UART_TX_PARITY_EN
         repeat (C) @(negedge clock);
         rec.parityBit = tx;
`endif
         repeat (C) @(negedge clock);
         rec.stopOk = (tx === 1'b1);
         frames.push_back(rec);
         repeat (C/2 - 1) @(negedge clock);
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drive one bus cycle across a rising edge, then release the store strobe.
   task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] data);
      bus.memwriteM  = we;
      bus.dataAdrM   = adr;
      bus.writedataM = data;
      @(posedge clock);
      #1;
      bus.memwriteM = 1'b0;
   endtask

   task automatic checkStatus(input string name, input logic [31:0] expected);
      bus.dataAdrM = BASE + 32'd4;
      #1;
      checkOutput({name, "_sel"}, {31'd0, bus.selIO}, 32'd1);
      checkOutput(name, bus.readDataIO, expected);
   endtask

   decodeVec_t decodeTab[6];
   frameVec_t  frameTab[4];

   initial begin
      int lowCount;
      checks = 0;
      errors = 0;
      bus.memwriteM  = 1'b0;
      bus.dataAdrM   = 32'd0;
      bus.writedataM = 32'd0;

      decodeTab[0] = '{BASE,                 1'b1, 32'h0};
      decodeTab[1] = '{BASE + 32'd4,         1'b1, 32'h2};
      decodeTab[2] = '{BASE + 32'd8,         1'b0, 32'h0};
      decodeTab[3] = '{BASE - 32'd4,         1'b0, 32'h0};
      decodeTab[4] = '{BASE + 32'd1,         1'b0, 32'h0};
      decodeTab[5] = '{32'h0000_0004,        1'b0, 32'h0};

      frameTab[0] = '{32'h00AB_CD55, 8'h55, 1'b0};
      frameTab[1] = '{32'h0000_0007, 8'h07, 1'b1};
      frameTab[2] = '{32'h0000_0003, 8'h03, 1'b0};
      frameTab[3] = '{32'hFFFF_FF80, 8'h80, 1'b1};

      // Reset held for two edges.
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      checkOutput("reset_tx", {31'd0, tx}, 32'd1);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkStatus("reset_status", 32'h2);

      // Address decode and load values in the idle state.
      for (int i = 0; i < 6; i++) begin
         bus.dataAdrM = decodeTab[i].adr;
         #1;
         checkOutput($sformatf("decode%0d_sel", i), {31'd0, bus.selIO}, {31'd0, decodeTab[i].expSel});
         checkOutput($sformatf("decode%0d_read", i), bus.readDataIO, decodeTab[i].expRead);
      end

      // Single frames with exact timing of start, busy and frame end.
      for (int i = 0; i < 4; i++) begin
         frames.delete();
         applyStimulus(1'b1, BASE, frameTab[i].wdata);
         @(posedge clock);
         #1;
         checkOutput($sformatf("frame%0d_startTx", i), {31'd0, tx}, 32'd0);
         checkOutput($sformatf("frame%0d_startBusy", i), {31'd0, busy}, 32'd1);
         repeat (FB*C - 1) @(posedge clock);
         #1;
         checkOutput($sformatf("frame%0d_lastBusy", i), {31'd0, busy}, 32'd1);
         checkOutput($sformatf("frame%0d_stopTx", i), {31'd0, tx}, 32'd1);
         @(posedge clock);
         #1;
         checkOutput($sformatf("frame%0d_endBusy", i), {31'd0, busy}, 32'd0);
         checkOutput($sformatf("frame%0d_count", i), frames.size(), 32'd1);
         if (frames.size() > 0) begin
            checkOutput($sformatf("frame%0d_data", i), {24'd0, frames[0].data}, {24'd0, frameTab[i].expByte});
            checkOutput($sformatf("frame%0d_startBit", i), {31'd0, frames[0].startOk}, 32'd1);
            checkOutput($sformatf("frame%0d_stopBit", i), {31'd0, frames[0].stopOk}, 32'd1);
`ifdef UART_TX_PARITY_EN
            checkOutput($sformatf("frame%0d_parity", i), {31'd0, frames[0].parityBit}, {31'd0, frameTab[i].expParity});
`endif
         end
      end

      // Burst of six stores: 0x01 popped, 0x02-0x05 fill the FIFO, 0x06 dropped.
      frames.delete();
      for (int i = 1; i <= 6; i++) begin
         applyStimulus(1'b1, BASE, 32'(i));
      end
      checkStatus("burst_fullStatus", 32'hD);
      // After the first frame ends, 0x02 is in flight and three bytes remain.
      repeat (40) @(posedge clock);
      checkStatus("burst_stickyStatus", 32'hC);
      applyStimulus(1'b1, BASE + 32'd4, 32'h8);
      checkStatus("burst_clearedStatus", 32'h4);
      for (int n = 0; n < 400; n++) begin
         if (frames.size() >= 5 && !busy) break;
         @(posedge clock);
      end
      #1;
      checkOutput("burst_count", frames.size(), 32'd5);
      for (int i = 0; i < 5; i++) begin
         if (frames.size() > i) begin
            checkOutput($sformatf("burst%0d_data", i), {24'd0, frames[i].data}, 32'(i + 1));
            checkOutput($sformatf("burst%0d_stop", i), {31'd0, frames[i].stopOk}, 32'd1);
            if (i > 0) begin
               checkOutput($sformatf("burst%0d_gap", i), frames[i].startCycle - frames[i-1].startCycle, FB*C);
            end
         end
      end
      checkStatus("burst_endStatus", 32'h2);

      // Reset in the middle of the data bits with three bytes still queued.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, BASE, 32'h11 * (i + 1));
      end
      repeat (C + 10) @(posedge clock);
      #1;
      checkOutput("midReset_busyBefore", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      checkOutput("midReset_tx", {31'd0, tx}, 32'd1);
      checkOutput("midReset_busy", {31'd0, busy}, 32'd0);
      checkStatus("midReset_status", 32'h2);
      lowCount = 0;
      for (int n = 0; n < 160; n++) begin
         @(posedge clock);
         #1;
         if (tx !== 1'b1) lowCount++;
         if (n == 59) frames.delete();
      end
      checkOutput("midReset_txLowCycles", lowCount, 32'd0);
      checkOutput("midReset_noFrames", frames.size(), 32'd0);

      // Stores outside TXDATA must not queue anything.
      frames.delete();
      bus.dataAdrM = BASE + 32'd8;
      #1;
      checkOutput("outside_sel", {31'd0, bus.selIO}, 32'd0);
      applyStimulus(1'b1, BASE + 32'd8, 32'h5A);
      applyStimulus(1'b1, BASE + 32'd4, 32'h77);
      repeat (60) @(posedge clock);
      #1;
      checkOutput("outside_busy", {31'd0, busy}, 32'd0);
      checkOutput("outside_noFrames", frames.size(), 32'd0);
      checkStatus("outside_status", 32'h2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
